// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage: default widths, the
// hard-wired zero register index, the stage entry layout and the write mux.
package wb_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int HIST_DEPTH = 2;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // One MEM-stage result as latched by the writeback stage register.
    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              memToReg;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] readData;
    } wb_entry_t;

    // Data the entry would write; an empty stage presents zero.
    function automatic logic [DATA_W-1:0] wb_select(input wb_entry_t e);
        logic [DATA_W-1:0] r;
        r = '0;
        if (e.valid) begin
            r = e.memToReg ? e.readData : e.aluResult;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_history.sv
// Shift register of the most recent committed regfile writes. Slot 0 is the
// newest. Two independent lookup ports return the newest matching slot.
module wb_history #(
    parameter int DEPTH  = wb_pkg::HIST_DEPTH,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [ADDR_W-1:0] lk1_rd_i,
    output logic              lk1_hit_o,
    output logic [DATA_W-1:0] lk1_data_o,
    input  logic [ADDR_W-1:0] lk2_rd_i,
    output logic              lk2_hit_o,
    output logic [DATA_W-1:0] lk2_data_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Push a commit into slot 0 and age every other slot by one; the oldest falls off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (push_i) begin
            vld_q[0]  <= 1'b1;
            rd_q[0]   <= push_rd_i;
            data_q[0] <= push_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                rd_q[i]   <= rd_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Port 1 lookup: scan oldest to newest so the newest match overwrites.
    always_comb begin
        lk1_hit_o  = 1'b0;
        lk1_data_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (rd_q[i] == lk1_rd_i)) begin
                lk1_hit_o  = 1'b1;
                lk1_data_o = data_q[i];
            end
        end
    end

    // Port 2 lookup: same priority rule as port 1.
    always_comb begin
        lk2_hit_o  = 1'b0;
        lk2_data_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (rd_q[i] == lk2_rd_i)) begin
                lk2_hit_o  = 1'b1;
                lk2_data_o = data_q[i];
            end
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB stage: latches MEM results, drives the regfile write port once per
// entry, counts commits and forwards pending/recent writes to decode.
// The stage entry layout comes from wb_pkg, so DATA_W/ADDR_W are expected to
// match the package defaults.
module writeback_unit #(
    parameter int DATA_W     = wb_pkg::DATA_W,
    parameter int ADDR_W     = wb_pkg::ADDR_W,
    parameter int HIST_DEPTH = wb_pkg::HIST_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              mem_valid,
    input  logic              mem_regWrite,
    input  logic              mem_memToReg,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_aluResult,
    input  logic [DATA_W-1:0] mem_readData,
    output logic              WB,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] fwdReg1,
    input  logic [ADDR_W-1:0] fwdReg2,
    output logic              fwdHit1,
    output logic              fwdHit2,
    output logic [DATA_W-1:0] fwdData1,
    output logic [DATA_W-1:0] fwdData2,
    output logic [31:0]       commitCount
);

    import wb_pkg::*;

    wb_entry_t         entry_q, entry_d;
    logic              done_q, done_d;
    logic [31:0]       commit_cnt_q, commit_cnt_d;
    logic              wb_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              h1_hit, h2_hit;
    logic [DATA_W-1:0] h1_data, h2_data;

    // done marks an entry that already wrote while held, so a stall never writes twice.
    assign wb_en   = entry_q.valid & entry_q.regWrite & (entry_q.rd != REG_ZERO) & ~done_q;
    assign wr_reg  = entry_q.valid ? entry_q.rd : REG_ZERO;
    assign wr_data = wb_select(entry_q);

    assign WB          = wb_en;
    assign writeReg    = wr_reg;
    assign writeData   = wr_data;
    assign commitCount = commit_cnt_q;

    // Next stage contents: load on any unstalled edge (even while committing), else hold.
    always_comb begin
        entry_d      = entry_q;
        done_d       = done_q;
        commit_cnt_d = commit_cnt_q;
        if (!stall) begin
            entry_d.valid     = mem_valid;
            entry_d.regWrite  = mem_regWrite;
            entry_d.memToReg  = mem_memToReg;
            entry_d.rd        = mem_rd;
            entry_d.aluResult = mem_aluResult;
            entry_d.readData  = mem_readData;
            done_d            = 1'b0;
        end else if (wb_en) begin
            done_d = 1'b1;
        end
        if (wb_en) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    // Stage register, single-write flag and commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q      <= '0;
            done_q       <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            entry_q      <= entry_d;
            done_q       <= done_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    wb_history #(
        .DEPTH  (HIST_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (wb_en),
        .push_rd_i   (wr_reg),
        .push_data_i (wr_data),
        .lk1_rd_i    (fwdReg1),
        .lk1_hit_o   (h1_hit),
        .lk1_data_o  (h1_data),
        .lk2_rd_i    (fwdReg2),
        .lk2_hit_o   (h2_hit),
        .lk2_data_o  (h2_data)
    );

    // Port 1 forwarding: r0 never hits; the pending write outranks history.
    always_comb begin
        fwdHit1  = 1'b0;
        fwdData1 = '0;
        if (fwdReg1 != REG_ZERO) begin
            if (wb_en && (wr_reg == fwdReg1)) begin
                fwdHit1  = 1'b1;
                fwdData1 = wr_data;
            end else if (h1_hit) begin
                fwdHit1  = 1'b1;
                fwdData1 = h1_data;
            end
        end
    end

    // Port 2 forwarding: same rules as port 1.
    always_comb begin
        fwdHit2  = 1'b0;
        fwdData2 = '0;
        if (fwdReg2 != REG_ZERO) begin
            if (wb_en && (wr_reg == fwdReg2)) begin
                fwdHit2  = 1'b1;
                fwdData2 = wr_data;
            end else if (h2_hit) begin
                fwdHit2  = 1'b1;
                fwdData2 = h2_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected regfile writes are queued when
// the MEM entry is driven and popped when the stage presents WB.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        mem_valid;
    logic        mem_regWrite;
    logic        mem_memToReg;
    logic [4:0]  mem_rd;
    logic [31:0] mem_aluResult;
    logic [31:0] mem_readData;
    logic        WB;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  fwdReg1;
    logic [4:0]  fwdReg2;
    logic        fwdHit1;
    logic        fwdHit2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;
    logic [31:0] commitCount;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks;
    int          errors;
    logic [31:0] exp_cnt;

    writeback_unit #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .HIST_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .mem_valid     (mem_valid),
        .mem_regWrite  (mem_regWrite),
        .mem_memToReg  (mem_memToReg),
        .mem_rd        (mem_rd),
        .mem_aluResult (mem_aluResult),
        .mem_readData  (mem_readData),
        .WB            (WB),
        .writeReg      (writeReg),
        .writeData     (writeData),
        .fwdReg1       (fwdReg1),
        .fwdReg2       (fwdReg2),
        .fwdHit1       (fwdHit1),
        .fwdHit2       (fwdHit2),
        .fwdData1      (fwdData1),
        .fwdData2      (fwdData2),
        .commitCount   (commitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 units after the edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld);
        wr_t w;
        mem_valid     = v;
        mem_regWrite  = rw;
        mem_memToReg  = m2r;
        mem_rd        = rd;
        mem_aluResult = alu;
        mem_readData  = ld;
        if (v && rw && rd != 5'd0) begin
            w.rd   = rd;
            w.data = m2r ? ld : alu;
            exp_q.push_back(w);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // Stage should be presenting the oldest queued write right now.
    task automatic sb_check(input string tag);
        wr_t w;
        chk({tag, "_wb"}, {31'd0, WB}, 32'd1);
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s_sb scoreboard empty while WB observed=%0h", tag, WB);
        end else begin
            w = exp_q.pop_front();
            chk({tag, "_reg"}, {27'd0, writeReg}, {27'd0, w.rd});
            chk({tag, "_data"}, writeData, w.data);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        fwdReg1 = 5'd0;
        fwdReg2 = 5'd0;
        idle();
        cycle();
        cycle();

        // Reset state
        chk("rst_wb", {31'd0, WB}, 32'd0);
        chk("rst_reg", {27'd0, writeReg}, 32'd0);
        chk("rst_data", writeData, 32'd0);
        chk("rst_cnt", commitCount, 32'd0);
        chk("rst_hit1", {31'd0, fwdHit1}, 32'd0);
        chk("rst_fdata1", fwdData1, 32'd0);
        rst_n = 1'b1;
        cycle();

        // ALU write to r9
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'd5, 32'd99);
        cycle();
        sb_check("alu");
        idle();
        cycle();
        exp_cnt = exp_cnt + 1;
        chk("alu_cnt", commitCount, exp_cnt);
        chk("alu_wb_off", {31'd0, WB}, 32'd0);

        // Load write to r10 selects readData
        drive(1'b1, 1'b1, 1'b1, 5'd10, 32'd77, 32'hDEAD_BEEF);
        cycle();
        sb_check("load");
        idle();
        cycle();
        exp_cnt = exp_cnt + 1;
        chk("load_cnt", commitCount, exp_cnt);

        // r0 write is filtered
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd123, 32'd0);
        cycle();
        fwdReg1 = 5'd0;
        fwdReg2 = 5'd10;
        #1;
        chk("r0_wb", {31'd0, WB}, 32'd0);
        chk("r0_data", writeData, 32'd123);
        chk("r0_fwd_hit1", {31'd0, fwdHit1}, 32'd0);
        chk("hist_r10_hit", {31'd0, fwdHit2}, 32'd1);
        chk("hist_r10_data", fwdData2, 32'hDEAD_BEEF);
        fwdReg2 = 5'd9;
        #1;
        chk("hist_r9_data", fwdData2, 32'd5);
        idle();
        cycle();
        chk("r0_cnt", commitCount, exp_cnt);

        // Stall: held entry writes exactly once
        drive(1'b1, 1'b1, 1'b0, 5'd11, 32'd4, 32'd0);
        cycle();
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd13, 32'd66, 32'd0);
        exp_q.pop_back();
        sb_check("stall");
        cycle();
        exp_cnt = exp_cnt + 1;
        chk("stall_wb2", {31'd0, WB}, 32'd0);
        chk("stall_hold_reg", {27'd0, writeReg}, 32'd11);
        chk("stall_cnt2", commitCount, exp_cnt);
        cycle();
        chk("stall_wb3", {31'd0, WB}, 32'd0);
        chk("stall_cnt3", commitCount, exp_cnt);
        idle();
        stall = 1'b0;
        cycle();
        chk("stall_cnt_end", commitCount, exp_cnt);

        // Forward priority: r9=1, r9=2 committed, r9=3 pending
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'd1, 32'd0);
        cycle();
        sb_check("f1");
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'd2, 32'd0);
        cycle();
        exp_cnt = exp_cnt + 1;
        sb_check("f2");
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'd3, 32'd0);
        cycle();
        exp_cnt = exp_cnt + 1;
        sb_check("f3");
        fwdReg1 = 5'd9;
        fwdReg2 = 5'd12;
        #1;
        chk("fwd_pend_hit", {31'd0, fwdHit1}, 32'd1);
        chk("fwd_pend_data", fwdData1, 32'd3);
        chk("fwd_cnt", commitCount, exp_cnt);
        idle();
        cycle();
        exp_cnt = exp_cnt + 1;
        chk("fwd_hist_data", fwdData1, 32'd3);
        chk("fwd_r12_hit", {31'd0, fwdHit2}, 32'd0);
        chk("fwd_r12_data", fwdData2, 32'd0);

        // Two commits to other regs age r9 out of a 2-deep history
        drive(1'b1, 1'b1, 1'b0, 5'd14, 32'd7, 32'd0);
        cycle();
        sb_check("age1");
        drive(1'b1, 1'b0 | 1'b1, 1'b1, 5'd15, 32'd0, 32'd8);
        cycle();
        exp_cnt = exp_cnt + 1;
        sb_check("age2");
        chk("age_r9_still", fwdData1, 32'd3);
        idle();
        cycle();
        exp_cnt = exp_cnt + 1;
        fwdReg2 = 5'd14;
        #1;
        chk("age_r9_hit", {31'd0, fwdHit1}, 32'd0);
        chk("age_r9_data", fwdData1, 32'd0);
        chk("age_r14_data", fwdData2, 32'd7);
        chk("age_cnt", commitCount, exp_cnt);

        // Reset mid-write drops the entry immediately
        fwdReg1 = 5'd15;
        drive(1'b1, 1'b1, 1'b0, 5'd16, 32'h55, 32'd0);
        exp_q.pop_back();
        cycle();
        chk("mid_wb_pre", {31'd0, WB}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb", {31'd0, WB}, 32'd0);
        chk("mid_rst_reg", {27'd0, writeReg}, 32'd0);
        chk("mid_rst_cnt", commitCount, 32'd0);
        chk("mid_rst_hit1", {31'd0, fwdHit1}, 32'd0);
        idle();
        cycle();
        chk("mid_rst_hold_wb", {31'd0, WB}, 32'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        cycle();
        chk("post_rst_cnt", commitCount, exp_cnt);

        // Counter wrap
        drive(1'b1, 1'b1, 1'b0, 5'd17, 32'hA, 32'd0);
        cycle();
        sb_check("wrap");
        force dut.commit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt_q;
        #1;
        chk("wrap_pre", commitCount, 32'hFFFF_FFFF);
        idle();
        cycle();
        chk("wrap_cnt", commitCount, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
